// File: rtl/mapu_pkg.sv
// Shared constants and row type for the Matrix APU row packer.
package mapu_pkg;

    localparam int MAPU_COLS = 3;
    localparam int MAPU_ROWS = 3;
    localparam int MAPU_DW   = 32;

    // One completed row as it travels through the row FIFO toward the APU.
    typedef struct packed {
        logic               mlast;
        logic [MAPU_DW-1:0] r0;
        logic [MAPU_DW-1:0] r1;
        logic [MAPU_DW-1:0] r2;
    } mapu_row_t;

    // A row closes its matrix when it is the last row slot or carries a terminator.
    function automatic logic row_is_mlast(input logic [1:0] row_cnt, input logic last);
        return last || (row_cnt == 2'(MAPU_ROWS - 1));
    endfunction

endpackage

// File: rtl/mapu_row_fifo.sv
// Synchronous FIFO of completed rows; same-cycle push and pop keep the count.
module mapu_row_fifo
    import mapu_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = mapu_row_t,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  T              wdata,
    input  logic          pop,
    output T              rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; reset discards all queued rows.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mapu_row_packer.sv
// Packs a scalar element stream into 3-element rows for the Matrix APU,
// tagging matrix-last rows, zero-padding short rows and buffering rows
// so APU backpressure never drops data.
module mapu_row_packer
    import mapu_pkg::*;
#(
    parameter int DATA_WIDTH = MAPU_DW,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [DATA_WIDTH-1:0] o_r0,
    output logic [DATA_WIDTH-1:0] o_r1,
    output logic [DATA_WIDTH-1:0] o_r2,
    output logic                  o_mlast,
    output logic                  o_short
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                  mlast;
        logic [DATA_WIDTH-1:0] r0;
        logic [DATA_WIDTH-1:0] r1;
        logic [DATA_WIDTH-1:0] r2;
    } row_t;

    logic [1:0]            col_cnt;
    logic [1:0]            row_cnt;
    logic [DATA_WIDTH-1:0] asm0;
    logic [DATA_WIDTH-1:0] asm1;
    logic                  short_q;

    logic                  accept;
    logic                  at_last_col;
    logic                  complete;
    logic                  row_mlast;
    logic                  short_hit;
    row_t                  row_new;
    row_t                  row_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_cnt;
    logic                  pop;

    // Ready depends only on registered occupancy, never on i_rdy, and stays
    // low whenever the FIFO is full even if the row in progress is not complete.
    assign o_rdy       = i_en && !reset && (int'(fifo_cnt) < FIFO_DEPTH);
    assign accept      = i_vld && o_rdy;
    assign at_last_col = (col_cnt == 2'(MAPU_COLS - 1));
    assign complete    = accept && (at_last_col || i_last);
    assign row_mlast   = row_is_mlast(row_cnt, i_last);
    assign short_hit   = accept && i_last && !(at_last_col && (row_cnt == 2'(MAPU_ROWS - 1)));
    assign pop         = o_vld && i_rdy;

    // Assemble the row being pushed: the completing element is used directly
    // and any columns beyond it are zero-filled.
    always_comb begin
        row_new       = '0;
        row_new.mlast = row_mlast;
        case (col_cnt)
            2'd0: begin
                row_new.r0 = i_data;
            end
            2'd1: begin
                row_new.r0 = asm0;
                row_new.r1 = i_data;
            end
            default: begin
                row_new.r0 = asm0;
                row_new.r1 = asm1;
                row_new.r2 = i_data;
            end
        endcase
    end

    // Column/row counters, assembly registers and the short-row pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt <= '0;
            row_cnt <= '0;
            asm0    <= '0;
            asm1    <= '0;
            short_q <= 1'b0;
        end else begin
            short_q <= short_hit;
            if (accept) begin
                if (col_cnt == 2'd0) begin
                    asm0 <= i_data;
                end
                if (col_cnt == 2'd1) begin
                    asm1 <= i_data;
                end
                if (complete) begin
                    col_cnt <= '0;
                    row_cnt <= row_mlast ? 2'd0 : row_cnt + 2'd1;
                end else begin
                    col_cnt <= col_cnt + 2'd1;
                end
            end
        end
    end

    // The full guard is redundant with o_rdy but keeps the FIFO safe standalone.
    mapu_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (row_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (complete && !fifo_full),
        .wdata (row_new),
        .pop   (pop),
        .rdata (row_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign o_vld   = !fifo_empty;
    assign o_r0    = row_head.r0;
    assign o_r1    = row_head.r1;
    assign o_r2    = row_head.r2;
    assign o_mlast = row_head.mlast;
    assign o_short = short_q;

endmodule

// File: tb/tb_mapu_row_packer.sv
// Self-checking bench for mapu_row_packer: element-level queue model plus
// directed scenarios with literal row expectations and a randomized run.
module tb_mapu_row_packer;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_en = 1'b0;
    logic          i_vld = 1'b0;
    logic          o_rdy;
    logic [DW-1:0] i_data = '0;
    logic          i_last = 1'b0;
    logic          o_vld;
    logic          i_rdy = 1'b0;
    logic [DW-1:0] o_r0;
    logic [DW-1:0] o_r1;
    logic [DW-1:0] o_r2;
    logic          o_mlast;
    logic          o_short;

    mapu_row_packer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_en    (i_en),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_r0    (o_r0),
        .o_r1    (o_r1),
        .o_r2    (o_r2),
        .o_mlast (o_mlast),
        .o_short (o_short)
    );

    always #5 clk = ~clk;

    typedef logic [3*DW:0] row_v;

    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;
    int   short_cnt = 0;
    int   rdy_mode = 0;
    bit   rdy_fixed = 1'b0;

    row_v        exp_q[$];
    logic [DW-1:0] part[$];
    int          row_idx = 0;
    bit          short_m = 1'b0;
    row_v        dut_log[$];

    function automatic row_v mk(input bit m, input int a, input int b, input int c);
        return {m, DW'(a), DW'(b), DW'(c)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: whole-element queue, rows formed from plain counting.
    always @(posedge clk) begin
        bit rdy_m;
        rdy_m = i_en && !reset && (exp_q.size() < DEPTH);
        if (reset) begin
            exp_q.delete();
            part.delete();
            row_idx = 0;
            short_m = 1'b0;
        end else begin
            short_m = 1'b0;
            if (exp_q.size() > 0 && i_rdy) void'(exp_q.pop_front());
            if (i_vld && rdy_m) begin
                part.push_back(i_data);
                if (i_last || part.size() == 3) begin
                    bit m;
                    logic [DW-1:0] e [3];
                    for (int k = 0; k < 3; k++) e[k] = (k < part.size()) ? part[k] : '0;
                    m = i_last || (row_idx == 2);
                    short_m = i_last && !(part.size() == 3 && row_idx == 2);
                    exp_q.push_back({m, e[0], e[1], e[2]});
                    row_idx = m ? 0 : row_idx + 1;
                    part.delete();
                end
            end
        end
    end

    // Record every row the DUT hands to the APU.
    always @(posedge clk) begin
        if (cmp_en && !reset && o_vld && i_rdy) dut_log.push_back({o_mlast, o_r0, o_r1, o_r2});
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("o_vld", o_vld, exp_q.size() != 0);
            chk("o_rdy", o_rdy, i_en && !reset && (exp_q.size() < DEPTH));
            chk("o_short", o_short, short_m);
            if (exp_q.size() != 0) chk("head_row", {o_mlast, o_r0, o_r1, o_r2}, exp_q[0]);
            if (o_short) short_cnt++;
        end
    end

    // APU ready generator.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       i_rdy = rdy_fixed;
            1:       i_rdy = !i_rdy;
            default: i_rdy = ($urandom % 2) == 1;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int n;
        bit r;
        n = 0;
        i_vld = 1'b1;
        i_data = d;
        i_last = l;
        forever begin
            @(negedge clk);
            r = o_rdy;
            @(posedge clk);
            #2;
            if (r) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=no_accept required=accept data=%0h", d);
                break;
            end
        end
        i_vld = 1'b0;
        i_last = 1'b0;
    endtask

    initial begin
        int b;
        int s;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_vld", o_vld, 0);
        chk("rst_rdy", o_rdy, 0);
        chk("rst_r0", o_r0, 0);
        chk("rst_mlast", o_mlast, 0);
        chk("rst_short", o_short, 0);
        reset = 1'b0;
        i_en = 1'b1;
        rdy_fixed = 1'b1;
        tick();
        tick();

        // Full 3x3 matrix with terminator on the ninth element.
        b = dut_log.size();
        s = short_cnt;
        for (int i = 1; i <= 9; i++) begin
            send(i, i == 9);
            if (i == 3) chk("latency_vld", o_vld, 1);
        end
        repeat (4) tick();
        chk("m1_count", dut_log.size(), b + 3);
        chk("m1_row0", dut_log[b], mk(0, 1, 2, 3));
        chk("m1_row1", dut_log[b + 1], mk(0, 4, 5, 6));
        chk("m1_row2", dut_log[b + 2], mk(1, 7, 8, 9));
        chk("m1_noshort", short_cnt, s);

        // Short row terminated at column 1.
        s = short_cnt;
        send(10, 0);
        send(11, 1);
        repeat (4) tick();
        chk("short_row", dut_log[b + 3], mk(1, 10, 11, 0));
        chk("short_pulse", short_cnt, s + 1);

        // Backpressure: FIFO fills, head held, then drained in order.
        b = dut_log.size();
        rdy_fixed = 1'b0;
        tick();
        for (int i = 1; i <= 6; i++) send(i, 0);
        i_vld = 1'b1;
        i_data = 7;
        repeat (3) begin
            tick();
            chk("bp_rdy_low", o_rdy, 0);
            chk("bp_head", {o_mlast, o_r0, o_r1, o_r2}, mk(0, 1, 2, 3));
        end
        rdy_fixed = 1'b1;
        send(7, 0);
        send(8, 0);
        send(9, 1);
        repeat (6) tick();
        chk("bp_count", dut_log.size(), b + 3);
        chk("bp_row0", dut_log[b], mk(0, 1, 2, 3));
        chk("bp_row1", dut_log[b + 1], mk(0, 4, 5, 6));
        chk("bp_row2", dut_log[b + 2], mk(1, 7, 8, 9));

        // Full FIFO with toggling APU ready.
        b = dut_log.size();
        rdy_fixed = 1'b0;
        tick();
        for (int i = 1; i <= 6; i++) send(i, 0);
        rdy_mode = 1;
        for (int i = 7; i <= 24; i++) send(i, i == 24);
        rdy_mode = 0;
        rdy_fixed = 1'b1;
        repeat (10) tick();
        chk("tog_count", dut_log.size(), b + 8);
        for (int k = 0; k < 8; k++)
            chk("tog_row", dut_log[b + k], mk((k % 3 == 2) || (k == 7), 3 * k + 1, 3 * k + 2, 3 * k + 3));

        // Enable gap in the middle of a row.
        b = dut_log.size();
        send(1, 0);
        send(2, 0);
        i_en = 1'b0;
        i_vld = 1'b1;
        i_data = 3;
        repeat (5) begin
            tick();
            chk("en_gap_rdy", o_rdy, 0);
        end
        i_en = 1'b1;
        send(3, 0);
        repeat (3) tick();
        chk("en_gap_row", dut_log[b], mk(0, 1, 2, 3));

        // Reset with a queued row and a partial row.
        b = dut_log.size();
        rdy_fixed = 1'b0;
        tick();
        send(4, 0);
        send(5, 0);
        send(6, 0);
        send(1, 0);
        send(2, 0);
        reset = 1'b1;
        tick();
        chk("mid_rst_rdy", o_rdy, 0);
        tick();
        chk("mid_rst_vld", o_vld, 0);
        chk("mid_rst_rdy2", o_rdy, 0);
        reset = 1'b0;
        rdy_fixed = 1'b1;
        send(7, 0);
        send(8, 0);
        send(9, 0);
        repeat (4) tick();
        chk("post_rst_count", dut_log.size(), b + 1);
        chk("post_rst_row", dut_log[b], mk(0, 7, 8, 9));

        // Randomized traffic with random APU ready, gaps and enable drops.
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            if ($urandom % 6 == 0) repeat ($urandom_range(1, 3)) tick();
            if ($urandom % 8 == 0) begin
                i_en = 1'b0;
                i_vld = $urandom % 2;
                repeat ($urandom_range(1, 3)) tick();
                i_en = 1'b1;
            end
            send($urandom, ($urandom % 5) == 0);
        end
        send($urandom, 1'b1);
        rdy_mode = 0;
        rdy_fixed = 1'b1;
        repeat (10) tick();
        chk("final_drain", o_vld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
